neuron_mac_par: RTL

Parametrised, multi-lane successor of the single-MAC neuron. It captures an input/weight vector on a start handshake and accumulates LANES signed products per cycle. It then adds bias, applies an arithmetic right shift and one of four activation modes, and saturates the result to DATA_W. It sits between layer controllers and the activation bus of the network datapath.

---
 rtl/neuron_pkg.sv | 36 +++
 rtl/neuron_act_sat.sv | 34 +++
 rtl/neuron_mac_par.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared types and helpers for the multi-lane neuron datapath: activation modes,
// controller states and the output saturation function.
package neuron_pkg;

    typedef enum logic [1:0] {
        ACT_ID    = 2'b00,
        ACT_RELU  = 2'b01,
        ACT_LEAKY = 2'b10,
        ACT_STEP  = 2'b11
    } act_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        ACT   = 2'b10
    } state_e;

    localparam int LEAKY_SHIFT = 3;
    localparam int SAT_W       = 64;

    // Clamp a wide signed value into the signed range of a data_w-bit word.
    function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                         input int data_w);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/neuron_act_sat.sv
// Combinational output stage: bias add, arithmetic shift, activation and
// saturation of the accumulated sum down to DATA_W.
module neuron_act_sat
    import neuron_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ACC_W     = 32,
    parameter int OUT_SHIFT = 0
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] bias_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] y_o
);

    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] s;
    logic signed [ACC_W-1:0] y;

    always_comb begin
        // The bias add wraps in the accumulator width before shifting.
        sum = $signed(acc_i) + ACC_W'($signed(bias_i));
        s   = sum >>> OUT_SHIFT;
        case (act_mode_e'(mode_i))
            ACT_ID:    y = s;
            ACT_RELU:  y = s[ACC_W-1] ? '0 : s;
            ACT_LEAKY: y = s[ACC_W-1] ? (s >>> LEAKY_SHIFT) : s;
            ACT_STEP:  y = (!s[ACC_W-1] && (s != '0)) ? ACC_W'(1) : '0;
            default:   y = s;
        endcase
        y_o = DATA_W'(saturate(SAT_W'(y), DATA_W));
    end

endmodule

// File: rtl/neuron_mac_par.sv
// Multi-lane neuron: captures an input/weight vector on start, accumulates LANES
// signed products per cycle, then activates and saturates the result.
module neuron_mac_par
    import neuron_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ACC_W       = 32,
    parameter int INPUT_COUNT = 62,
    parameter int LANES       = 2,
    parameter int OUT_SHIFT   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [INPUT_COUNT*DATA_W-1:0] inputs,
    input  logic [INPUT_COUNT*DATA_W-1:0] weights,
    input  logic [DATA_W-1:0]             bias,
    input  logic [1:0]                    ctrl_data,
    output logic                          ready,
    output logic                          out_valid,
    output logic [DATA_W-1:0]             out,
    output logic [1:0]                    dbg_state
);

    localparam int N_STEPS = (INPUT_COUNT + LANES - 1) / LANES;
    localparam int STEP_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
    localparam int VEC_W   = INPUT_COUNT * DATA_W;

    // Handshake: a start is taken on any rising edge where ready is high; ready
    // is high only in IDLE, including the cycle in which out_valid pulses.
    state_e                  state_q, state_d;
    logic [STEP_W-1:0]       step_q, step_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [VEC_W-1:0]        x_q, w_q;
    logic [DATA_W-1:0]       bias_q;
    logic [1:0]              mode_q;
    logic [DATA_W-1:0]       out_q;
    logic                    out_valid_q;
    logic                    load;
    logic                    fire;
    logic [DATA_W-1:0]       act_y;

    logic [ACC_W-1:0]        lane_sum;
    logic signed [DATA_W-1:0]   lx, lw;
    logic signed [2*DATA_W-1:0] prod;
    int                      idx;

    // Lanes beyond INPUT_COUNT in the final step contribute nothing.
    always_comb begin
        lane_sum = '0;
        lx       = '0;
        lw       = '0;
        prod     = '0;
        idx      = 0;
        for (int l = 0; l < LANES; l++) begin
            idx = int'(step_q) * LANES + l;
            if (idx < INPUT_COUNT) begin
                lx       = x_q[idx*DATA_W +: DATA_W];
                lw       = w_q[idx*DATA_W +: DATA_W];
                prod     = lx * lw;
                lane_sum = lane_sum + ACC_W'(prod);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        load    = 1'b0;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    acc_d   = '0;
                    step_d  = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + lane_sum;
                if (step_q == STEP_W'(N_STEPS - 1)) begin
                    step_d  = '0;
                    state_d = ACT;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            ACT: begin
                fire    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    neuron_act_sat #(
        .DATA_W   (DATA_W),
        .ACC_W    (ACC_W),
        .OUT_SHIFT(OUT_SHIFT)
    ) u_act_sat (
        .acc_i (acc_q),
        .bias_i(bias_q),
        .mode_i(mode_q),
        .y_o   (act_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            step_q      <= '0;
            acc_q       <= '0;
            x_q         <= '0;
            w_q         <= '0;
            bias_q      <= '0;
            mode_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            acc_q       <= acc_d;
            out_valid_q <= fire;
            if (fire) begin
                out_q <= act_y;
            end
            if (load) begin
                x_q    <= inputs;
                w_q    <= weights;
                bias_q <= bias;
                mode_q <= ctrl_data;
            end
        end
    end

    assign ready     = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign dbg_state = state_q;

endmodule
